// File: rtl/sram_responder.sv
// sram_responder: pin-level stand-in for a 512Kx8 asynchronous SRAM behind sram_ctrl.
// Samples the SRAM pins on clk, commits writes held for at least WR_MIN cycles and
// drives read data RD_LAT cycles after a stable read address is seen.
// Optional build macro SRAM_RESPONDER_PATTERN_INIT_EN fills the array with
// i[7:0] ^ 8'hA5 after every reset, holding init_busy high during the sweep.
module sram_responder #(
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH_W = 10,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned WR_MIN  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] ad,
    inout  wire  [DATA_W-1:0] dio_a,
    input  logic              we_n,
    input  logic              oe_n,
    input  logic              ce_a_n,
    output logic [15:0]       wr_count,
    output logic              err_short_we,
    output logic              err_addr_glitch,
    output logic              init_busy
);

    localparam int unsigned CNT_MAX = (RD_LAT > WR_MIN) ? RD_LAT : WR_MIN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RdLatC = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] WrMinC = CNT_W'(WR_MIN);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StReadWait,
        StReadDrive
`ifdef SRAM_RESPONDER_PATTERN_INIT_EN
        , StInit
`endif
    } state_e;

`ifdef SRAM_RESPONDER_PATTERN_INIT_EN
    localparam state_e StReset = StInit;
`else
    localparam state_e StReset = StIdle;
`endif

    state_e state_q, state_d;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drive_q, drive_d;
    logic [15:0]        wr_count_q, wr_count_d;
    logic               err_short_q, err_short_d;
    logic               err_glitch_q, err_glitch_d;

    logic [DATA_W-1:0]  mem [2**DEPTH_W];
    logic               mem_we;
    logic [DEPTH_W-1:0] mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;

`ifdef SRAM_RESPONDER_PATTERN_INIT_EN
    logic [DEPTH_W-1:0] init_idx_q, init_idx_d;
    logic [7:0]         init_pat;
`endif

    logic sel, wr, rd, addr_moved;

    // Pin decode; a low we_n always wins over oe_n.
    assign sel        = !ce_a_n;
    assign wr         = sel && !we_n;
    assign rd         = sel && we_n && !oe_n;
    assign addr_moved = (ad != addr_q);
    assign mem_rdata  = mem[addr_q[DEPTH_W-1:0]];

    // State register; a reset drops any in-flight write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (wr) begin
                    state_d = StWrite;
                end else if (rd) begin
                    state_d = StReadWait;
                end
            end
            StWrite: begin
                if (!wr) begin
                    state_d = StIdle;
                end
            end
            StReadWait: begin
                if (wr) begin
                    state_d = StWrite;
                end else if (!rd) begin
                    state_d = StIdle;
                end else if (!addr_moved && (cnt_q == RdLatC)) begin
                    state_d = StReadDrive;
                end
            end
            StReadDrive: begin
                if (wr) begin
                    state_d = StWrite;
                end else if (!rd) begin
                    state_d = StIdle;
                end else if (addr_moved) begin
                    state_d = StReadWait;
                end
            end
`ifdef SRAM_RESPONDER_PATTERN_INIT_EN
            StInit: begin
                if (init_idx_q == '1) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state, array write port and error pulses.
    always_comb begin
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        drive_d      = drive_q;
        wr_count_d   = wr_count_q;
        err_short_d  = 1'b0;
        err_glitch_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = addr_q[DEPTH_W-1:0];
        mem_wdata    = wdata_q;
`ifdef SRAM_RESPONDER_PATTERN_INIT_EN
        init_idx_d   = init_idx_q;
        init_pat     = 8'(init_idx_q) ^ 8'hA5;
`endif
        case (state_q)
            StIdle, StReadWait, StReadDrive: begin
                if (wr) begin
                    // Write entry is the same from every non-write state.
                    addr_d  = ad;
                    wdata_d = dio_a;
                    cnt_d   = CntOne;
                    drive_d = 1'b0;
                end else if (state_q == StIdle) begin
                    if (rd) begin
                        addr_d = ad;
                        cnt_d  = CntOne;
                    end
                end else if (!rd) begin
                    drive_d = 1'b0;
                end else if (addr_moved) begin
                    // New address restarts the access time.
                    drive_d = 1'b0;
                    addr_d  = ad;
                    cnt_d   = CntOne;
                end else if (state_q == StReadWait) begin
                    if (cnt_q == RdLatC) begin
                        rdata_d = mem_rdata;
                        drive_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end
            StWrite: begin
                if (wr) begin
                    wdata_d = dio_a;
                    if (cnt_q < WrMinC) begin
                        cnt_d = cnt_q + CntOne;
                    end
                    if (addr_moved) begin
                        err_glitch_d = 1'b1;
                        addr_d       = ad;
                    end
                end else if (cnt_q >= WrMinC) begin
                    mem_we = 1'b1;
                    if (wr_count_q != 16'hFFFF) begin
                        wr_count_d = wr_count_q + 16'd1;
                    end
                end else begin
                    err_short_d = 1'b1;
                end
            end
`ifdef SRAM_RESPONDER_PATTERN_INIT_EN
            StInit: begin
                mem_we     = 1'b1;
                mem_waddr  = init_idx_q;
                mem_wdata  = DATA_W'(init_pat);
                init_idx_d = init_idx_q + 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Datapath registers; drive_q reset releases dio_a asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            drive_q      <= 1'b0;
            wr_count_q   <= '0;
            err_short_q  <= 1'b0;
            err_glitch_q <= 1'b0;
`ifdef SRAM_RESPONDER_PATTERN_INIT_EN
            init_idx_q   <= '0;
`endif
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            drive_q      <= drive_d;
            wr_count_q   <= wr_count_d;
            err_short_q  <= err_short_d;
            err_glitch_q <= err_glitch_d;
`ifdef SRAM_RESPONDER_PATTERN_INIT_EN
            init_idx_q   <= init_idx_d;
`endif
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign dio_a           = drive_q ? rdata_q : {DATA_W{1'bz}};
    assign wr_count        = wr_count_q;
    assign err_short_we    = err_short_q;
    assign err_addr_glitch = err_glitch_q;
`ifdef SRAM_RESPONDER_PATTERN_INIT_EN
    assign init_busy       = (state_q == StInit);
`else
    assign init_busy       = 1'b0;
`endif

endmodule
